// File: rtl/pac_game_controller.sv
// PAC-MAN game-state sequencer: dot map, score, lives, level and freeze/respawn control.
// All state advances once per frame_tick; outputs come straight from registers.
module pac_game_controller #(
  parameter logic [143:0] INIT_DOTS   = {144{1'b1}},
  parameter int unsigned  DOT_POINTS  = 10,
  parameter int unsigned  HOLD_FRAMES = 60,
  parameter int unsigned  START_LIVES = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_tick,
  input  logic         start,
  input  logic [9:0]   BallX,
  input  logic [9:0]   BallY,
  input  logic [9:0]   Ball_size,
  input  logic [9:0]   oghostx,
  input  logic [9:0]   oghosty,
  input  logic [9:0]   bghostx,
  input  logic [9:0]   bghosty,
  input  logic [9:0]   rghostx,
  input  logic [9:0]   rghosty,
  input  logic [9:0]   pghostx,
  input  logic [9:0]   pghosty,
  output logic [143:0] currDotMap,
  output logic [1:0]   level,
  output logic [15:0]  score,
  output logic [1:0]   lives,
  output logic [2:0]   game_state,
  output logic         freeze,
  output logic         respawn
);

  localparam int unsigned MAP_W  = 144;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DEATH = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  function automatic logic [CNT_W-1:0] popcount(input logic [MAP_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAP_W; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  localparam logic [CNT_W-1:0]  INIT_COUNT = popcount(INIT_DOTS);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES);
  localparam logic [1:0]        LIVES_INIT = 2'(START_LIVES);

  // Box overlap test on unwrapped 11-bit differences
  function automatic logic ghost_hit(input logic [9:0] ax, input logic [9:0] ay,
                                     input logic [9:0] gx, input logic [9:0] gy,
                                     input logic [9:0] sz);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]        adx;
    logic [10:0]        ady;
    dx  = $signed({1'b0, ax}) - $signed({1'b0, gx});
    dy  = $signed({1'b0, ay}) - $signed({1'b0, gy});
    adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    return (adx < {1'b0, sz}) && (ady < {1'b0, sz});
  endfunction

  logic [2:0]        state_q, state_d;
  logic [MAP_W-1:0]  dots_q, dots_d;
  logic [1:0]        level_q, level_d;
  logic [15:0]       score_q, score_d;
  logic [1:0]        lives_q, lives_d;
  logic              freeze_q, freeze_d;
  logic              respawn_q, respawn_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  left_q, left_d;

  logic [9:0]  px_c, py_c;
  logic [7:0]  idx_c;
  logic        on_dot_c, dot_here_c, collide_c;
  logic [16:0] score_sum_c;

  // Tile lookup and collision, evaluated from the current input sample
  always_comb begin
    px_c        = BallX + 10'd2 - 10'd32;
    py_c        = BallY + 10'd2 - 10'd32;
    on_dot_c    = (px_c[4:0] <= 5'd3) && (py_c[4:0] <= 5'd3) &&
                  (px_c[9:5] < 5'd12) && (py_c[9:5] < 5'd12);
    idx_c       = 8'(py_c[9:5]) * 8'd12 + 8'(px_c[9:5]);
    dot_here_c  = on_dot_c && dots_q[idx_c];
    collide_c   = ghost_hit(BallX, BallY, oghostx, oghosty, Ball_size) ||
                  ghost_hit(BallX, BallY, bghostx, bghosty, Ball_size) ||
                  ghost_hit(BallX, BallY, rghostx, rghosty, Ball_size) ||
                  ghost_hit(BallX, BallY, pghostx, pghosty, Ball_size);
    score_sum_c = {1'b0, score_q} + 17'(DOT_POINTS);
  end

  always_comb begin
    state_d   = state_q;
    dots_d    = dots_q;
    level_d   = level_q;
    score_d   = score_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    hold_d    = hold_q;
    left_d    = left_q;
    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end
        end
        S_PLAY: begin
          if (collide_c) begin
            state_d = S_DEATH;
            lives_d = lives_q - 2'd1;
            hold_d  = '0;
          end else if (dot_here_c) begin
            dots_d[idx_c] = 1'b0;
            score_d       = score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
            left_d        = left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) begin
              state_d = S_CLEAR;
              hold_d  = '0;
            end
          end
        end
        S_DEATH: begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_d == HOLD_LAST) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d   = S_PLAY;
              respawn_d = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_d == HOLD_LAST) begin
            level_d   = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
            dots_d    = INIT_DOTS;
            left_d    = INIT_COUNT;
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end
        end
        S_OVER: begin
          if (start) begin
            score_d   = '0;
            lives_d   = LIVES_INIT;
            level_d   = '0;
            dots_d    = INIT_DOTS;
            left_d    = INIT_COUNT;
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    freeze_d = (state_d != S_PLAY);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      dots_q    <= INIT_DOTS;
      level_q   <= '0;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
      hold_q    <= '0;
      left_q    <= INIT_COUNT;
    end else begin
      state_q   <= state_d;
      dots_q    <= dots_d;
      level_q   <= level_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
    end
  end

  assign currDotMap = dots_q;
  assign level      = level_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_state = state_q;
  assign freeze     = freeze_q;
  assign respawn    = respawn_q;

endmodule

// File: tb/tb_pac_game_controller.sv
// Directed bench for pac_game_controller: three instances with different parameters
// share stimulus; each is held in reset while another is exercised.
module tb_pac_game_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        frame_tick, start;
  logic [9:0]  ball_x, ball_y, ball_size;
  logic [9:0]  ogx, ogy, bgx, bgy, rgx, rgy, pgx, pgy;

  logic [143:0] map_a, map_b, map_c;
  logic [1:0]   level_a, level_b, level_c;
  logic [15:0]  score_a, score_b, score_c;
  logic [1:0]   lives_a, lives_b, lives_c;
  logic [2:0]   state_a, state_b, state_c;
  logic         freeze_a, freeze_b, freeze_c;
  logic         respawn_a, respawn_b, respawn_c;

  localparam logic [143:0] ALL_DOTS = {144{1'b1}};

  pac_game_controller dut_a (
    .Clk(clk), .Reset_n(rst_a), .frame_tick(frame_tick), .start(start),
    .BallX(ball_x), .BallY(ball_y), .Ball_size(ball_size),
    .oghostx(ogx), .oghosty(ogy), .bghostx(bgx), .bghosty(bgy),
    .rghostx(rgx), .rghosty(rgy), .pghostx(pgx), .pghosty(pgy),
    .currDotMap(map_a), .level(level_a), .score(score_a), .lives(lives_a),
    .game_state(state_a), .freeze(freeze_a), .respawn(respawn_a));

  pac_game_controller #(.INIT_DOTS(144'h1)) dut_b (
    .Clk(clk), .Reset_n(rst_b), .frame_tick(frame_tick), .start(start),
    .BallX(ball_x), .BallY(ball_y), .Ball_size(ball_size),
    .oghostx(ogx), .oghosty(ogy), .bghostx(bgx), .bghosty(bgy),
    .rghostx(rgx), .rghosty(rgy), .pghostx(pgx), .pghosty(pgy),
    .currDotMap(map_b), .level(level_b), .score(score_b), .lives(lives_b),
    .game_state(state_b), .freeze(freeze_b), .respawn(respawn_b));

  pac_game_controller #(.DOT_POINTS(32764)) dut_c (
    .Clk(clk), .Reset_n(rst_c), .frame_tick(frame_tick), .start(start),
    .BallX(ball_x), .BallY(ball_y), .Ball_size(ball_size),
    .oghostx(ogx), .oghosty(ogy), .bghostx(bgx), .bghosty(bgy),
    .rghostx(rgx), .rghosty(rgy), .pghostx(pgx), .pghosty(pgy),
    .currDotMap(map_c), .level(level_c), .score(score_c), .lives(lives_c),
    .game_state(state_c), .freeze(freeze_c), .respawn(respawn_c));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One-clock tick pulse; returns at the falling edge after the sampling edge
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ghosts_far();
    ogx = 10'd1000; ogy = 10'd1000; bgx = 10'd1000; bgy = 10'd1000;
    rgx = 10'd1000; rgy = 10'd1000; pgx = 10'd1000; pgy = 10'd1000;
  endtask

  task automatic set_ball(input int x, input int y);
    ball_x = 10'(x);
    ball_y = 10'(y);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    frame_tick = 1'b0; start = 1'b0;
    ball_size = 10'd16;
    set_ball(500, 500);
    ghosts_far();
    #2 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk);

    // ---------------- default instance ----------------
    check("rst_state",   144'(state_a), 144'(0));
    check("rst_freeze",  144'(freeze_a), 144'(1));
    check("rst_respawn", 144'(respawn_a), 144'(0));
    check("rst_lives",   144'(lives_a), 144'(3));
    check("rst_score",   144'(score_a), 144'(0));
    check("rst_level",   144'(level_a), 144'(0));
    check("rst_map",     map_a, ALL_DOTS);
    check("rst_map_b",   map_b, 144'h1);
    rst_a = 1'b1;
    tick();
    check("idle_no_start", 144'(state_a), 144'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state",   144'(state_a), 144'(1));
    check("start_respawn", 144'(respawn_a), 144'(1));
    check("start_freeze",  144'(freeze_a), 144'(0));
    check("start_map",     map_a, ALL_DOTS);
    @(negedge clk);
    check("respawn_pulse_end", 144'(respawn_a), 144'(0));

    set_ball(32, 32);
    tick();
    check("eat0_bit",   144'(map_a[0]), 144'(0));
    check("eat0_score", 144'(score_a), 144'(10));
    tick();
    check("eat0_again", 144'(score_a), 144'(10));

    set_ball(96, 64);
    tick();
    check("eat14_bit",   144'(map_a[14]), 144'(0));
    check("eat14_score", 144'(score_a), 144'(20));
    set_ball(50, 64);
    tick();
    check("off_cell_score", 144'(score_a), 144'(20));
    check("off_cell_map",   map_a, ALL_DOTS & ~144'h1 & ~(144'h1 << 14));

    // collision beats an eatable dot at idx 3
    set_ball(128, 32);
    ogx = 10'd133; ogy = 10'd32;
    tick();
    ghosts_far();
    check("coll1_state", 144'(state_a), 144'(2));
    check("coll1_lives", 144'(lives_a), 144'(2));
    check("coll1_dot",   144'(map_a[3]), 144'(1));
    check("coll1_score", 144'(score_a), 144'(20));
    check("coll1_freeze", 144'(freeze_a), 144'(1));
    start = 1'b1;
    ticks(59);
    check("death_hold59", 144'(state_a), 144'(2));
    tick();
    start = 1'b0;
    check("death_to_play", 144'(state_a), 144'(1));
    check("death_respawn", 144'(respawn_a), 144'(1));
    check("death_freeze",  144'(freeze_a), 144'(0));

    // mid-frame position change without a tick has no effect
    set_ball(32, 32);
    repeat (3) @(negedge clk);
    set_ball(128, 32);
    repeat (3) @(negedge clk);
    check("midframe_map",   144'(map_a[3]), 144'(1));
    check("midframe_score", 144'(score_a), 144'(20));
    tick();
    check("eat3_score", 144'(score_a), 144'(30));

    set_ball(160, 32);
    pgx = 10'd160; pgy = 10'd40;
    tick();
    ghosts_far();
    check("coll2_lives", 144'(lives_a), 144'(1));
    check("coll2_dot",   144'(map_a[4]), 144'(1));
    ticks(60);
    check("coll2_play", 144'(state_a), 144'(1));
    rgx = 10'd150; rgy = 10'd30;
    tick();
    ghosts_far();
    check("coll3_lives", 144'(lives_a), 144'(0));
    ticks(60);
    check("over_state",   144'(state_a), 144'(4));
    check("over_freeze",  144'(freeze_a), 144'(1));
    check("over_respawn", 144'(respawn_a), 144'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("newgame_state", 144'(state_a), 144'(1));
    check("newgame_score", 144'(score_a), 144'(0));
    check("newgame_lives", 144'(lives_a), 144'(3));
    check("newgame_level", 144'(level_a), 144'(0));
    check("newgame_map",   map_a, ALL_DOTS);
    check("newgame_respawn", 144'(respawn_a), 144'(1));

    // asynchronous reset in the middle of a death hold
    bgx = 10'd170; bgy = 10'd32;
    tick();
    ghosts_far();
    check("coll4_lives", 144'(lives_a), 144'(2));
    ticks(30);
    #2 rst_a = 1'b0;
    #1;
    check("arst_state",  144'(state_a), 144'(0));
    check("arst_lives",  144'(lives_a), 144'(3));
    check("arst_freeze", 144'(freeze_a), 144'(1));
    @(negedge clk) rst_a = 1'b1;
    tick();
    check("arst_idle", 144'(state_a), 144'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arst_restart", 144'(state_a), 144'(1));
    rst_a = 1'b0;

    // ---------------- single-dot instance ----------------
    set_ball(500, 500);
    @(negedge clk) rst_b = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_ball(32, 32);
    ogx = 10'd36; ogy = 10'd32;
    tick();
    ghosts_far();
    check("b_lastdot_coll", 144'(state_b), 144'(2));
    check("b_lastdot_map",  map_b, 144'h1);
    ticks(60);
    check("b_back_play", 144'(state_b), 144'(1));
    tick();
    check("b_clear_state", 144'(state_b), 144'(3));
    check("b_clear_map",   map_b, 144'h0);
    check("b_clear_score", 144'(score_b), 144'(10));
    ticks(59);
    check("b_clear_hold59", 144'(state_b), 144'(3));
    tick();
    check("b_level1",  144'(level_b), 144'(1));
    check("b_reload",  map_b, 144'h1);
    check("b_respawn", 144'(respawn_b), 144'(1));
    check("b_lives",   144'(lives_b), 144'(2));
    for (int lv = 2; lv <= 4; lv++) begin
      tick();
      check("b_clear_again", 144'(state_b), 144'(3));
      ticks(60);
      check("b_level_sat", 144'(level_b), 144'(lv > 3 ? 3 : lv));
      check("b_reload_again", map_b, 144'h1);
    end
    rst_b = 1'b0;

    // ---------------- large-points instance: saturation ----------------
    set_ball(500, 500);
    @(negedge clk) rst_c = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_ball(32, 32);
    tick();
    check("c_score1", 144'(score_c), 144'(16'h7FFC));
    set_ball(64, 32);
    tick();
    check("c_score2", 144'(score_c), 144'(16'hFFF8));
    set_ball(96, 32);
    tick();
    check("c_score_sat", 144'(score_c), 144'(16'hFFFF));
    check("c_map", 144'(map_c[2:0]), 144'(0));
    set_ball(128, 32);
    tick();
    check("c_score_hold", 144'(score_c), 144'(16'hFFFF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pac_game_controller.md
# pac_game_controller

Game-state sequencer for the PAC-MAN datapath. It owns the 144-bit dot map and the 2-bit level that the color mapper renders. Once per frame it samples Pac-Man and ghost positions, erases eaten dots, keeps score, lives and level, and detects ghost collisions. It freezes and respawns the movement units around death, level-clear and game-over intervals.

## Interface
Parameters:
- INIT_DOTS, 144'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, dot map loaded at reset, level start and new game; bit index = row*12 + col
- DOT_POINTS, 10, score added per eaten dot
- HOLD_FRAMES, 60, frame_ticks spent in DEATH and CLEAR
- START_LIVES, 3, lives at reset and new game (1..3)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-Clk pulse per video frame (vsync edge)
- start  in  1  level-sensitive; sampled only in IDLE/OVER
- BallX, BallY  in  10 each  Pac-Man center
- Ball_size  in  10  sprite half-size; collision threshold
- oghostx, oghosty, bghostx, bghosty, rghostx, rghosty, pghostx, pghosty  in  10 each  ghost centers
- currDotMap  out  144  remaining dots; 1 = dot present
- level  out  2  current level, 0..3
- score  out  16  saturating score
- lives  out  2  remaining lives
- game_state  out  3  0 IDLE, 1 PLAY, 2 DEATH, 3 CLEAR, 4 OVER
- freeze  out  1  high in every state except PLAY; movement units hold position
- respawn  out  1  one-Clk pulse; movement units reload start positions

## Operation
- All outputs are registered.
- Reset values: game_state IDLE, currDotMap INIT_DOTS, level 0, score 0, lives START_LIVES, freeze 1, respawn 0. The internal hold counter resets to 0 and dots_left to popcount(INIT_DOTS).
- Tile lookup, computed from the sampled position:
  - px = BallX+2-32, py = BallY+2-32, both 10-bit wrap.
  - Pac-Man is on a dot cell when px[4:0]<=3, py[4:0]<=3, px[9:5]<12 and py[9:5]<12.
  - idx = py[9:5]*12 + px[9:5], 8-bit.
- Collision with ghost g: |BallX-gx| < Ball_size and |BallY-gy| < Ball_size. Use 11-bit signed differences with no wrap. OR the result over all four ghosts.
- Work happens only on frame_tick. Between ticks every register holds.
- IDLE:
  - start=1 on a tick: go to PLAY and pulse respawn.
- PLAY, on each tick:
  - If any collision: go to DEATH, lives-=1, hold counter=0. No dot is eaten on that tick.
  - Else if on a dot cell and currDotMap[idx]=1:
    - Clear the bit.
    - score = min(score+DOT_POINTS, 16'hFFFF).
    - dots_left-=1.
    - If dots_left becomes 0: go to CLEAR with hold counter=0.
  - Else: no change.
- DEATH, on each tick:
  - Increment the hold counter.
  - When it reaches HOLD_FRAMES: if lives==0 go to OVER; else go to PLAY and pulse respawn.
  - currDotMap, score and level are unchanged.
- CLEAR, on each tick:
  - Increment the hold counter.
  - When it reaches HOLD_FRAMES:
    - level = min(level+1, 3).
    - Reload currDotMap=INIT_DOTS and dots_left.
    - Go to PLAY and pulse respawn.
  - Lives are unchanged.
- OVER:
  - start=1 on a tick: score=0, lives=START_LIVES, level=0, reload the map, go to PLAY and pulse respawn.
- freeze = (game_state != PLAY), registered together with game_state.

## Timing
- A tick sampled at rising edge n produces all state, map, score and lives updates visible after edge n. Latency is 1 Clk.
- respawn is high for exactly the one Clk following the transition edge into PLAY. It is never asserted with freeze=1.
- A collision and an eatable dot on the same tick: the collision wins; the map and score are untouched.
- A collision on the same tick the last dot would be eaten: the game enters DEATH, and dots_left stays 1.
- Score saturates: 16'hFFF8 + 10 = 16'hFFFF.
- Level saturates: CLEAR at level 3 reloads the map and level stays 3.
- Position inputs change mid-frame with no effect; only values at the tick edge matter.
- Reset_n low at any time, including mid-DEATH hold: outputs return to their reset values asynchronously. Operation resumes on the first tick after release.
- start held high in PLAY, DEATH or CLEAR is ignored.

## Test plan
- Reset, then tick with start=1: game_state 0->1, respawn high 1 Clk, freeze 1->0, currDotMap=INIT_DOTS.
- PLAY, BallX=BallY=32 (idx 0), ghosts far away, tick: bit 0 cleared, score 0->10. A second tick at the same position leaves score at 10.
- BallX=96, BallY=64 (col 2, row 1, idx 14), tick: bit 14 cleared. BallX=50 (px[4:0]=20): no change.
- Ghost at (BallX+5, BallY), Ball_size=16, dot present under Pac-Man, tick: game_state=2, lives 3->2, dot still 1. After 60 ticks: state 1 with a respawn pulse. With lives=1 at collision: after 60 ticks state 4. start then gives score 0, lives 3, level 0.
- INIT_DOTS with only bit 0 set: eat idx 0, state 3; after 60 ticks level 0->1, map reloaded, respawn pulse. Repeat from level 3: level stays 3.
- Assert Reset_n low 30 ticks into DEATH: outputs reset immediately. Force score to 16'hFFF8 and eat a dot: score 16'hFFFF.
